// File: rtl/core_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit (shift-add multiply, restoring divide).
// Latency: XLEN+1 cycles from accept to o_valid; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: accepts only in IDLE; holds the result in DONE until i_ready; i_flush aborts at any time.
module core_mdu #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_num1u,
  input  logic [XLEN-1:0] i_num2u,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_res,
  output logic            o_busy
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   mcand_q;   // multiplicand for MUL*, divisor magnitude for DIV*/REM*
  logic [2*XLEN-1:0] acc_q;     // {hi, lo}: product/multiplier or remainder/dividend-quotient
  logic [CW-1:0]     cnt_q;
  logic              neg_quo_q; // negate product or quotient at completion
  logic              neg_rem_q; // negate remainder at completion
  logic [XLEN-1:0]   res_q;

  logic              accept;
  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem_nx;
  logic [2*XLEN-1:0] acc_nx;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
  logic              last;

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_busy  = (state_q == S_CALC);
  assign o_res   = o_valid ? res_q : '0;

  assign accept = i_valid & o_ready & ~i_flush;
  assign last   = (cnt_q == CW'(XLEN - 1));

  // Operand decode: signedness, magnitudes and the single-cycle special cases
  always_comb begin
    a_sgn    = (i_funct3 == 3'b001) | (i_funct3 == 3'b010) | (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
    b_sgn    = (i_funct3 == 3'b001) | (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
    a_neg    = a_sgn & i_num1u[XLEN-1];
    b_neg    = b_sgn & i_num2u[XLEN-1];
    a_mag    = a_neg ? (~i_num1u + 1'b1) : i_num1u;
    b_mag    = b_neg ? (~i_num2u + 1'b1) : i_num2u;
    is_div   = i_funct3[2];
    div_zero = is_div & (i_num2u == '0);
    div_ovf  = is_div & ~i_funct3[0] & (i_num1u == {1'b1, {(XLEN-1){1'b0}}}) & (&i_num2u);
    if (div_zero) special_res = i_funct3[1] ? i_num1u : '1;
    else          special_res = i_funct3[1] ? '0 : i_num1u;
  end

  // One iteration step plus sign correction of the completed value
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_sh     = acc_q[2*XLEN-1:XLEN-1];
    div_ge     = (div_sh >= {1'b0, mcand_q});
    div_rem_nx = div_ge ? XLEN'(div_sh - {1'b0, mcand_q}) : div_sh[XLEN-1:0];
    if (f3_q[2]) acc_nx = {div_rem_nx, acc_q[XLEN-2:0], div_ge};
    else         acc_nx = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = neg_quo_q ? (~acc_nx + 1'b1) : acc_nx;
    quo_fix  = neg_quo_q ? (~acc_nx[XLEN-1:0] + 1'b1) : acc_nx[XLEN-1:0];
    rem_fix  = neg_rem_q ? (~acc_nx[2*XLEN-1:XLEN] + 1'b1) : acc_nx[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:          fin_res = prod_fix[XLEN-1:0];
      3'b100, 3'b101:  fin_res = quo_fix;
      3'b110, 3'b111:  fin_res = rem_fix;
      default:         fin_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // Control FSM and datapath registers; flush overrides everything else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      f3_q      <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else if (i_flush) begin
      state_q <= S_IDLE;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            f3_q      <= i_funct3;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            mcand_q   <= is_div ? b_mag : a_mag;
            acc_q     <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            if (div_zero | div_ovf) begin
              res_q   <= special_res;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_nx;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            res_q   <= fin_res;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            res_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mdu.sv
// Self-checking bench for core_mdu (XLEN=32): directed vectors, random ops against an
// arithmetic reference, stall, flush and asynchronous reset scenarios.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_core_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_num1u = '0;
  logic [31:0] i_num2u = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_res;
  logic        o_busy;

  int errors = 0;
  int checks = 0;

  core_mdu #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_funct3(i_funct3),
    .i_num1u (i_num1u),
    .i_num2u (i_num2u),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic on the RISC-V rules
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, sp;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    case (f)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * ub; return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE and wait (bounded) for o_valid; lat counts cycles after the accept edge
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    i_valid = 1'b1; i_funct3 = f; i_num1u = a; i_num2u = b;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = o_res;
  endtask

  // Take the result and confirm the unit is back in IDLE
  task automatic retire(input string tag);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_retire"}, {o_valid, o_ready, o_busy, o_res}, {1'b0, 1'b1, 1'b0, 32'h0});
  endtask

  task automatic directed(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] r;
    int          l;
    run_op(f, a, b, r, l);
    check({tag, "_res"}, r, exp_res);
    check({tag, "_lat"}, l, exp_lat);
    retire(tag);
  endtask

  logic [31:0] r0, ra, rb;
  logic [2:0]  rf;
  int          lat;
  logic        ok, seen;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_ready, o_valid, o_busy, o_res}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    directed("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    directed("mulhu_ff",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    directed("mulh_ff",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         33);
    directed("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    directed("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    directed("divu_100_7",  3'd5, 32'd100,        32'd7,         32'd14,        33);
    directed("div_by0",     3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    directed("remu_by0",    3'd7, 32'd5,          32'd0,         32'd5,         1);
    directed("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(rf, ra, rb, r0, lat);
      check($sformatf("rand%0d_f%0d_res", i, rf), r0, model(rf, ra, rb));
      check($sformatf("rand%0d_f%0d_lat", i, rf), lat, model_lat(rf, ra, rb));
      retire($sformatf("rand%0d", i));
    end

    // Stall in DONE: result and handshake held for 10 cycles
    run_op(3'd0, 32'd1234, 32'd5678, r0, lat);
    check("stall_res", r0, 32'd7006652);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (o_res !== r0 || o_ready !== 1'b0 || o_valid !== 1'b1) ok = 1'b0;
    end
    check("stall_hold", ok, 1'b1);
    retire("stall");

    // Flush at CALC cycle 5
    @(negedge clk);
    i_valid = 1'b1; i_funct3 = 3'd0; i_num1u = 32'd9; i_num2u = 32'd9;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("calc_busy_res0", {o_busy, o_valid, o_res}, {1'b1, 1'b0, 32'h0});
    repeat (4) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_idle", {o_ready, o_busy, o_valid}, {1'b1, 1'b0, 1'b0});
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    check("flush_no_valid", seen, 1'b0);

    // Asynchronous reset mid-CALC, then MUL on the first edge after release
    @(negedge clk);
    i_valid = 1'b1; i_funct3 = 3'd4; i_num1u = 32'd1000; i_num2u = 32'd3;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {o_ready, o_valid, o_busy, o_res}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    i_valid = 1'b1; i_funct3 = 3'd0; i_num1u = 32'd3; i_num2u = 32'd4;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("post_reset_accept", o_busy, 1'b1);
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("post_reset_mul_res", o_res, 32'd12);
    check("post_reset_mul_lat", lat, 33);
    retire("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_mdu.md
CORE_MDU -- requirements
Module: core_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 i_valid  input  1  request present.
REQ-005 o_ready  output  1  unit can accept a request this cycle.
REQ-006 i_funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 i_num1u, i_num2u  input  XLEN  rs1, rs2 operands (raw bits).
REQ-008 i_flush  input  1  abort in-flight op (pipeline kill).
REQ-009 o_valid  output  1  o_res holds a completed result.
REQ-010 i_ready  input  1  consumer takes result this cycle.
REQ-011 o_res  output  XLEN  result.
REQ-012 o_busy  output  1  high in CALC state (stall hint to pipeline).

Function
REQ-013 FSM states IDLE, CALC, DONE; o_ready = (state==IDLE); o_valid = (state==DONE); o_busy = (state==CALC).
REQ-014 Accept = i_valid & o_ready & ~i_flush; on accept, latch funct3 and operands, go to CALC.
REQ-015 Operands converted to magnitude per signedness (MULH/DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; others unsigned); result sign fixed by negation at completion.
REQ-016 Multiply: shift-add, one rs2 bit per cycle, 2*XLEN-bit product; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits.
REQ-017 Divide: restoring, one quotient bit per cycle; quotient sign = sign(rs1) XOR sign(rs2), remainder sign = sign(rs1).
REQ-018 Normal latency: CALC lasts exactly XLEN cycles; o_valid asserts on cycle XLEN+1 after the accept edge.
REQ-019 Divide by zero: skip iteration, DONE one cycle after accept; DIV/DIVU result all-ones, REM/REMU result = rs1.
REQ-020 Signed overflow (DIV/REM, rs1 = -2^(XLEN-1), rs2 = -1): DONE one cycle after accept; DIV result = rs1, REM result = 0.
REQ-021 DONE holds o_res and o_valid stable until i_ready; on o_valid & i_ready go to IDLE next cycle; no new accept in the handoff cycle.
REQ-022 i_flush in any state: next state IDLE, o_valid deasserted next cycle, result discarded; flush wins over simultaneous i_valid and i_ready.
REQ-023 Iteration counter width clog2(XLEN)+1; no wrap within one op.
REQ-024 o_res equals 0 whenever o_valid is low.

Reset
REQ-025 While i_rst_n low: state IDLE, o_ready=1, o_valid=0, o_busy=0, o_res=0, counter and datapath registers 0.
REQ-026 Reset asserted mid-CALC or in DONE aborts immediately; no result emitted after release.
REQ-027 First accept possible on the first rising edge after i_rst_n deasserts.

Verification
REQ-028 XLEN=32, MUL 7 x -3 (0xFFFFFFFD) -> o_res 0xFFFFFFEB, o_valid 33 cycles after accept.
REQ-029 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-030 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
REQ-031 DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; all one cycle after accept.
REQ-032 i_ready held low 10 cycles in DONE -> o_res stable, o_ready low; i_flush at CALC cycle 5 -> IDLE next cycle, no o_valid pulse.
REQ-033 i_rst_n pulsed low mid-CALC -> all outputs at reset values asynchronously; following MUL 3 x 4 -> 12.
